// File: rtl/led_index_sequencer.sv
// LED index sequencer: prescaled up/down/ping-pong/hold walk of a 3-bit index.
// Optional synchronous index load is compiled in with `define LED_SEQ_LOAD_EN.
module led_index_sequencer #(
    parameter int unsigned DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 load,
    input  logic [2:0]           load_value,
    output logic [2:0]           index,
    output logic                 tick,
    output logic                 dir
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_PING = 2'b11
    } mode_t;

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [2:0]           r_index;
    logic                 r_dir;
    logic                 r_tick;

    mode_t                w_mode;
    logic [2:0]           w_step_index;
    logic                 w_step_dir;
    logic                 w_terminal;

    assign w_mode     = mode_t'(mode);
    // Greater-or-equal so a shrinking div terminates the period instead of wrapping.
    assign w_terminal = (r_cnt >= div);

    always_comb begin
        w_step_index = r_index;
        w_step_dir   = r_dir;
        unique case (w_mode)
            MODE_HOLD: ;
            MODE_UP: begin
                w_step_index = r_index + 3'd1;
                w_step_dir   = 1'b0;
            end
            MODE_DOWN: begin
                w_step_index = r_index - 3'd1;
                w_step_dir   = 1'b1;
            end
            MODE_PING: begin
                if (!r_dir) begin
                    if (r_index == 3'd7) begin
                        w_step_index = 3'd6;
                        w_step_dir   = 1'b1;
                    end else begin
                        w_step_index = r_index + 3'd1;
                    end
                end else begin
                    if (r_index == 3'd0) begin
                        w_step_index = 3'd1;
                        w_step_dir   = 1'b0;
                    end else begin
                        w_step_index = r_index - 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_index <= '0;
            r_dir   <= 1'b0;
            r_tick  <= 1'b0;
        end
`ifdef LED_SEQ_LOAD_EN
        else if (load) begin
            r_cnt   <= '0;
            r_index <= load_value;
            r_tick  <= 1'b0;
        end
`endif
        else if (enable) begin
            if (w_terminal) begin
                r_cnt   <= '0;
                r_tick  <= 1'b1;
                r_index <= w_step_index;
                r_dir   <= w_step_dir;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

`ifndef LED_SEQ_LOAD_EN
    logic w_unused_load;
    assign w_unused_load = ^{load, load_value};
`endif

    assign index = r_index;
    assign tick  = r_tick;
    assign dir   = r_dir;

endmodule

// File: doc/led_index_sequencer.md
# led_index_sequencer

Upstream stage of the LED decoder: generates the 3-bit LED index that the decoder turns into an active-low one-hot LED pattern. A programmable prescaler paces index steps, and the index walks up, down, ping-pong or holds. An optional synchronous load repositions the index. Outputs are registered, so `index` drives the decoder's `switch` input directly.

## Interface
- `DIV_WIDTH`, default 4: prescaler width; step period is `div+1` enabled cycles.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state.
- `enable`  in  1  advance prescaler/sequencer when high; freeze all state when low.
- `mode`  in  2  00 hold, 01 up, 10 down, 11 ping-pong.
- `div`  in  DIV_WIDTH  prescaler terminal value.
- `load`  in  1  synchronous index load request (see Configuration).
- `load_value`  in  3  index value to load.
- `index`  out  3  current LED index, to the decoder's `switch`.
- `tick`  out  1  one-cycle pulse on the cycle `index` takes its stepped value.
- `dir`  out  1  current direction, 0 up, 1 down.

## Operation
- State: prescaler `cnt[DIV_WIDTH-1:0]`, `index[2:0]`, `dir`, `tick`.
- Priority per rising edge: `rst` > `load` > `enable` step > hold.
- `load`=1 (feature compiled in):
  - `index`<=`load_value`, `cnt`<=0, `tick`<=0.
  - `dir` unchanged.
  - Ignores `enable`.
- `enable`=0, no load: `cnt`, `index`, `dir` hold; `tick`<=0.
- `enable`=1, `cnt` < `div`: `cnt`<=`cnt`+1; `tick`<=0.
- `enable`=1, `cnt` >= `div`: `cnt`<=0; `tick`<=1; step `index` per `mode`:
  - 00 hold: `index`, `dir` unchanged; `tick` still pulses.
  - 01 up: `index`<=`index`+1 mod 8 (7->0); `dir`<=0.
  - 10 down: `index`<=`index`-1 mod 8 (0->7); `dir`<=1.
  - 11 ping-pong, `dir`=0:
    - `index`=7: `dir`<=1, `index`<=6.
    - otherwise: `index`+1.
  - 11 ping-pong, `dir`=1:
    - `index`=0: `dir`<=0, `index`<=1.
    - otherwise: `index`-1.
  - Ends are never repeated: sequence 5,6,7,6,5...
- The `>=` compare is mandatory. If `div` shrinks below `cnt` mid-count, the next enabled cycle terminates immediately; no 2^DIV_WIDTH wrap.
- `div`=0: step on every enabled cycle; `tick` stays high while enabled.
- `mode` changes take effect at the next step. Ping-pong entered with any `dir` continues in that direction.

## Timing
- Reset values: `index`=0, `tick`=0, `dir`=0, `cnt`=0. Applied asynchronously on `rst` high and held while high.
- All outputs are registered; no combinational input-to-output path.
- `tick` and the new `index` appear on the same edge.
- Each step takes `div+1` enabled cycles. Disabled cycles stretch the period without losing count.
- After reset release with `enable`=1: first `tick` at edge `div+1`.
- Load: `index`=`load_value` one edge after `load` is sampled. The next step occurs `div+1` enabled cycles later.
- `rst` mid-count: immediate clear; counting restarts from 0 after release.

## Configuration
- `LED_SEQ_LOAD_EN` defined: `load`/`load_value` behave as above.
- `LED_SEQ_LOAD_EN` undefined: `load` and `load_value` are ignored and no load logic is synthesised. Ports remain so instantiation is unchanged.
- All other behaviour is identical in both builds.

## Test plan
- Reset, `enable`=1, mode 01, `div`=2 -> `tick` at edges 3,6,9; `index` 1,2,3; `dir`=0.
- Mode 01, `div`=0, start `index`=6 -> `index` 7,0,1 on consecutive cycles; `tick` held high.
- Mode 11, `div`=0, from `index`=5, `dir`=0 -> 6,7,6,5; `dir` 0->1 on the edge `index` becomes 6 after 7.
- Mode 01, `div`=7: run to `cnt`=5, then `div`<=2 -> `tick` on the next enabled edge, `cnt`=0.
- Mode 10, `div`=1: toggle `enable` low for 3 cycles mid-period -> `index`, `cnt`, `dir` frozen; `tick`=0; period resumes with the remaining count.
- With `LED_SEQ_LOAD_EN`: `load`=1, `load_value`=4 together with `enable`=1 at step time -> `index`=4, `tick`=0, `cnt`=0. Without the macro -> load ignored, normal step occurs.
